// File: rtl/fillv_pkg.sv
// fillv_pkg: shared element-type codes, modes, FSM states and element-geometry helpers
package fillv_pkg;
  localparam logic [2:0] BYTE_ = 3'd0, HALF_ = 3'd1, WORD_ = 3'd2, DOUBLE_ = 3'd3, VECTOR_ = 3'd4;
  localparam logic MODE_SPLAT = 1'b0, MODE_INSERT = 1'b1;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int unsigned elem_bits(input logic [2:0] dtype);
    return dtype <= DOUBLE_ ? 32'd8 << dtype : 32'd0;
  endfunction
  function automatic int unsigned lanes(input logic [2:0] dtype, input int unsigned vlen);
    return dtype <= DOUBLE_ ? vlen / elem_bits(dtype) : 32'd1;
  endfunction
endpackage

// File: rtl/fillv_stream_if.sv
// fillv_stream_if: command port and beat output port of the vector fill streamer
interface fillv_stream_if #(
  parameter int VLEN = 128,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 4,
  parameter int LANE_W = 4
);
  logic cmd_valid, cmd_ready, cmd_mode;
  logic [2:0] cmd_dtype;
  logic [LANE_W-1:0] cmd_lane;
  logic [VLEN-1:0] cmd_imm, cmd_base;
  logic [ADDR_W-1:0] cmd_dst;
  logic [CNT_W-1:0] cmd_count;
  logic out_valid, out_ready, out_last, err, busy;
  logic [VLEN-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  modport master (
    output cmd_valid, cmd_mode, cmd_dtype, cmd_lane, cmd_imm, cmd_base, cmd_dst, cmd_count, out_ready,
    input cmd_ready, out_valid, out_last, out_data, out_addr, err, busy
  );
  modport slave (
    input cmd_valid, cmd_mode, cmd_dtype, cmd_lane, cmd_imm, cmd_base, cmd_dst, cmd_count, out_ready,
    output cmd_ready, out_valid, out_last, out_data, out_addr, err, busy
  );
endinterface

// File: rtl/fillv_lane_mux.sv
// fillv_lane_mux: builds the splat or single-lane-insert fill vector and flags illegal commands
module fillv_lane_mux
  import fillv_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int LANE_W = 4
) (
  input  logic [2:0]        dtype,
  input  logic              mode,
  input  logic [LANE_W-1:0] lane,
  input  logic [VLEN-1:0]   imm,
  input  logic [VLEN-1:0]   base,
  output logic [VLEN-1:0]   vec,
  output logic              illegal
);
  logic [VLEN-1:0] splat, ins;
  always_comb begin
    splat = '0;
    ins = '0;
    for (int i = 0; i < VLEN; i++) begin
      splat[i] = dtype == BYTE_ ? imm[i % 8] : dtype == HALF_ ? imm[i % 16] :
                 dtype == WORD_ ? imm[i % 32] : imm[i % 64];
      // the splat bit is exactly the immediate bit that lands in the selected lane
      ins[i] = 32'(lane) == (dtype == BYTE_ ? i / 8 : dtype == HALF_ ? i / 16 :
               dtype == WORD_ ? i / 32 : i / 64) ? splat[i] : base[i];
    end
    illegal = dtype > VECTOR_ ||
              (mode == MODE_INSERT && dtype != VECTOR_ && 32'(lane) >= lanes(dtype, VLEN));
    vec = dtype == VECTOR_ ? imm : mode == MODE_INSERT ? ins : splat;
  end
endmodule

// File: rtl/fillv_stream.sv
// fillv_stream: accepts one fill command and streams the fill vector to consecutive registers
module fillv_stream
  import fillv_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 4,
  parameter int LANE_W = 4
) (
  input logic           clk,
  input logic           reset_n,
  fillv_stream_if.slave io
);
  state_t state, state_n;
  logic [VLEN-1:0] vec, data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0] remaining;
  logic illegal, accept, fire, err_q;
  fillv_lane_mux #(.VLEN(VLEN), .LANE_W(LANE_W)) u_mux (
    .dtype(io.cmd_dtype), .mode(io.cmd_mode), .lane(io.cmd_lane),
    .imm(io.cmd_imm), .base(io.cmd_base), .vec(vec), .illegal(illegal)
  );
  assign io.cmd_ready = state == IDLE;
  assign io.out_valid = state == STREAM;
  assign io.busy = state != IDLE;
  assign io.out_last = state == STREAM && remaining == CNT_W'(1);
  assign io.out_data = data_q;
  assign io.out_addr = addr_q;
  assign io.err = err_q;
  always_comb begin
    accept = io.cmd_valid && io.cmd_ready;
    fire = io.out_valid && io.out_ready;
    state_n = state == IDLE ? (accept && !illegal && io.cmd_count != '0 ? STREAM : IDLE)
                            : (fire && remaining == CNT_W'(1) ? IDLE : STREAM);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      data_q <= '0;
      addr_q <= '0;
      remaining <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= accept && illegal;
      if (accept) begin
        data_q <= vec;
        addr_q <= io.cmd_dst;
        remaining <= io.cmd_count;
      end else if (fire) begin
        addr_q <= addr_q + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end
endmodule
